// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Holds the operation codes, divider state constants and small decode helpers.
package muldiv_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_MULT  = 3'd0;
    localparam op_t OP_MULTU = 3'd1;
    localparam op_t OP_DIV   = 3'd2;
    localparam op_t OP_DIVU  = 3'd3;
    localparam op_t OP_MTHI  = 3'd4;
    localparam op_t OP_MTLO  = 3'd5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // One restoring step per quotient bit.
    function automatic int div_iters(input int width);
        return width;
    endfunction

    function automatic logic is_div_op(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on magnitudes,
// with sign fix-up and divide-by-zero result selection applied in the DONE cycle.
module div_radix2
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_quo,
    output logic [WIDTH-1:0] o_rem
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(div_iters(WIDTH) - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_quo_neg;
    logic             r_rem_neg;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_raw_a;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    assign w_a_neg = i_signed & i_a[WIDTH-1];
    assign w_b_neg = i_signed & i_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -i_a : i_a;
    assign w_b_mag = w_b_neg ? -i_b : i_b;

    // The dividend is shifted out of r_quo into r_rem as quotient bits shift in.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift[WIDTH-1:0] - r_div;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_quo_neg  <= 1'b0;
            r_rem_neg  <= 1'b0;
            r_div_zero <= 1'b0;
            r_raw_a    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_flush) begin
                        r_state    <= ST_RUN;
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_quo      <= w_a_mag;
                        r_div      <= w_b_mag;
                        r_quo_neg  <= w_a_neg ^ w_b_neg;
                        r_rem_neg  <= w_a_neg;
                        r_div_zero <= (i_b == '0);
                        r_raw_a    <= i_a;
                    end
                end
                ST_RUN: begin
                    if (i_flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_DONE) && !i_flush;

    // A zero divisor bypasses sign correction: HI returns the dividend untouched.
    assign o_quo = r_div_zero ? {WIDTH{1'b1}} : (r_quo_neg ? -r_quo : r_quo);
    assign o_rem = r_div_zero ? r_raw_a       : (r_rem_neg ? -r_rem : r_rem);

endmodule

// File: rtl/muldiv_hilo.sv
// EX-stage multiply/divide unit owning HI/LO: single-cycle multiply and MTHI/MTLO,
// iterative divide through div_radix2 with a pipeline stall while it runs.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_div_busy;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_eff_start;
    logic               w_div_start;
    logic [2*WIDTH-1:0] w_a_sx;
    logic [2*WIDTH-1:0] w_b_sx;
    logic [2*WIDTH-1:0] w_a_zx;
    logic [2*WIDTH-1:0] w_b_zx;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;

    // While a divide is in flight start_i still belongs to that stalled instruction.
    assign w_eff_start = start_i && !flush_i && !w_div_busy;
    assign w_div_start = w_eff_start && is_div_op(op_t'(op_i));

    div_radix2 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_div_start),
        .i_flush  (flush_i),
        .i_signed (op_i == OP_DIV),
        .i_a      (src_a_i),
        .i_b      (src_b_i),
        .o_done   (w_div_done),
        .o_busy   (w_div_busy),
        .o_quo    (w_div_quo),
        .o_rem    (w_div_rem)
    );

    // Low 2*WIDTH bits of the extended product equal the true signed/unsigned product.
    assign w_a_sx   = {{WIDTH{src_a_i[WIDTH-1]}}, src_a_i};
    assign w_b_sx   = {{WIDTH{src_b_i[WIDTH-1]}}, src_b_i};
    assign w_a_zx   = {{WIDTH{1'b0}}, src_a_i};
    assign w_b_zx   = {{WIDTH{1'b0}}, src_b_i};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = w_a_zx * w_b_zx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_div_done) begin
            r_hi <= w_div_rem;
            r_lo <= w_div_quo;
        end else if (w_eff_start) begin
            case (op_i)
                OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                OP_MTHI:  r_hi <= src_a_i;
                OP_MTLO:  r_lo <= src_a_i;
                default: begin
                end
            endcase
        end
    end

    assign stall_o = w_div_start || (w_div_busy && !w_div_done && !flush_i);
    assign busy_o  = w_div_busy;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: directed corner cases plus randomized ops
// compared against an arithmetic HI/LO reference model.
module tb_muldiv_hilo;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        stall_o;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_tests = 0;
    int          n_fail  = 0;

    muldiv_hilo #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .start_i (start_i),
        .op_i    (op_i),
        .src_a_i (src_a_i),
        .src_b_i (src_b_i),
        .stall_o (stall_o),
        .busy_o  (busy_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog hi_o=%h lo_o=%h required bench completion", hi_o, lo_o);
        $fatal(1, "watchdog expired");
    end

    // Architectural result {HI,LO} of one operation, from plain integer arithmetic.
    function automatic logic [63:0] ref_hilo(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = {hi, lo};
        case (op)
            OP_MULT:  p = sa * sb;
            OP_MULTU: p = {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            OP_MTHI: p = {a, lo};
            OP_MTLO: p = {hi, a};
            default: p = {hi, lo};
        endcase
        return p;
    endfunction

    // Starts at a negedge, issues one single-cycle op, ends at the next negedge.
    task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
        logic [63:0] exp;
        start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
        exp = ref_hilo(op, a, b, m_hi, m_lo);
        #1;
        n_tests++;
        if (stall_o !== 1'b0) begin
            $display("FAIL %s stall_o got %b want 0", tag, stall_o); n_fail++;
        end
        @(negedge clk);
        start_i = 1'b0;
        {m_hi, m_lo} = exp;
        n_tests++;
        if (hi_o !== m_hi) begin
            $display("FAIL %s hi_o got %h want %h", tag, hi_o, m_hi); n_fail++;
        end
        n_tests++;
        if (lo_o !== m_lo) begin
            $display("FAIL %s lo_o got %h want %h", tag, lo_o, m_lo); n_fail++;
        end
    endtask

    // Full divide with start_i held for the whole stalled instruction (start cycle .. DONE).
    task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string tag, input bit keep_start);
        logic [63:0] exp;
        int stall_cnt;
        exp = ref_hilo(op, a, b, m_hi, m_lo);
        start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
        stall_cnt = 0;
        for (int c = 1; c <= 34; c++) begin
            #1;
            if (stall_o === 1'b1) stall_cnt++;
            if (c == 2) begin
                n_tests++;
                if (busy_o !== 1'b1) begin
                    $display("FAIL %s busy_o got %b want 1", tag, busy_o); n_fail++;
                end
            end
            if (c == 34) begin
                n_tests++;
                if (stall_o !== 1'b0) begin
                    $display("FAIL %s done-cycle stall_o got %b want 0", tag, stall_o); n_fail++;
                end
            end
            @(negedge clk);
            if (c == 33) begin
                n_tests++;
                if (hi_o !== m_hi || lo_o !== m_lo) begin
                    $display("FAIL %s early hilo got %h_%h want %h_%h", tag, hi_o, lo_o, m_hi, m_lo);
                    n_fail++;
                end
            end
        end
        if (!keep_start) start_i = 1'b0;
        {m_hi, m_lo} = exp;
        n_tests++;
        if (stall_cnt != 33) begin
            $display("FAIL %s stall cycles got %0d want 33", tag, stall_cnt); n_fail++;
        end
        n_tests++;
        if (hi_o !== m_hi) begin
            $display("FAIL %s hi_o got %h want %h", tag, hi_o, m_hi); n_fail++;
        end
        n_tests++;
        if (lo_o !== m_lo) begin
            $display("FAIL %s lo_o got %h want %h", tag, lo_o, m_lo); n_fail++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; flush_i = 1'b0; start_i = 1'b0;
        op_i = 3'd0; src_a_i = 32'd0; src_b_i = 32'd0;
        repeat (3) @(negedge clk);
        m_hi = 32'd0; m_lo = 32'd0;
        n_tests++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
            $display("FAIL reset hilo got %h_%h want 0_0", hi_o, lo_o); n_fail++;
        end
        n_tests++;
        if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
            $display("FAIL reset busy/stall got %b/%b want 0/0", busy_o, stall_o); n_fail++;
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        issue_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, "mult_neg");
        issue_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, "multu_big");
        issue_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin");
        for (int i = 0; i < 4; i++) begin
            issue_op(OP_MULT,  $urandom, $urandom, "mult_rand");
            issue_op(OP_MULTU, $urandom, $urandom, "multu_rand");
        end
    endtask

    task automatic test_mthilo();
        issue_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0, "mthi");
        issue_op(OP_MTLO, 32'h0BAD_F00D, 32'd0, "mtlo");
    endtask

    task automatic test_div();
        run_div(OP_DIV,  32'hFFFF_FFF9, 32'd2, "div_neg7_2", 1'b0);
        run_div(OP_DIVU, 32'd100, 32'd7, "divu_100_7", 1'b0);
        run_div(OP_DIVU, 32'h1234_5678, 32'd0, "divu_by0", 1'b0);
        run_div(OP_DIV,  32'hFFFF_FF00, 32'd0, "div_neg_by0", 1'b0);
        run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 1'b0);
        run_div(OP_DIV,  32'd7, 32'hFFFF_FFFE, "div_7_neg2", 1'b0);
    endtask

    task automatic test_flush();
        issue_op(OP_MTHI, 32'h1111_1111, 32'd0, "flush_prep_hi");
        issue_op(OP_MTLO, 32'h2222_2222, 32'd0, "flush_prep_lo");
        // Flush at RUN cnt=10: the 12th cycle counting the start cycle as 1.
        start_i = 1'b1; op_i = OP_DIV; src_a_i = $urandom; src_b_i = $urandom | 32'd1;
        repeat (11) @(negedge clk);
        flush_i = 1'b1;
        #1;
        n_tests++;
        if (stall_o !== 1'b0) begin
            $display("FAIL flush_run stall_o got %b want 0", stall_o); n_fail++;
        end
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0;
        n_tests++;
        if (busy_o !== 1'b0) begin
            $display("FAIL flush_run busy_o got %b want 0", busy_o); n_fail++;
        end
        n_tests++;
        if (hi_o !== m_hi || lo_o !== m_lo) begin
            $display("FAIL flush_run hilo got %h_%h want %h_%h", hi_o, lo_o, m_hi, m_lo); n_fail++;
        end
        // Flush landing in the DONE cycle drops the result.
        start_i = 1'b1; op_i = OP_DIVU; src_a_i = 32'd1000; src_b_i = 32'd3;
        repeat (33) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0;
        n_tests++;
        if (hi_o !== m_hi || lo_o !== m_lo || busy_o !== 1'b0) begin
            $display("FAIL flush_done hilo/busy got %h_%h/%b want %h_%h/0", hi_o, lo_o, busy_o, m_hi, m_lo);
            n_fail++;
        end
        // Flush in IDLE suppresses both a write and a divide start.
        start_i = 1'b1; op_i = OP_MTHI; src_a_i = 32'hCAFE_0000; flush_i = 1'b1;
        @(negedge clk);
        op_i = OP_DIV;
        #1;
        n_tests++;
        if (stall_o !== 1'b0) begin
            $display("FAIL flush_idle stall_o got %b want 0", stall_o); n_fail++;
        end
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0;
        n_tests++;
        if (hi_o !== m_hi || busy_o !== 1'b0) begin
            $display("FAIL flush_idle hi/busy got %h/%b want %h/0", hi_o, busy_o, m_hi); n_fail++;
        end
        // Reset at cnt=10 aborts and clears HI/LO.
        start_i = 1'b1; op_i = OP_DIV; src_a_i = $urandom; src_b_i = $urandom | 32'd1;
        repeat (11) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        n_tests++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0 || busy_o !== 1'b0) begin
            $display("FAIL reset_run hilo/busy got %h_%h/%b want 0_0/0", hi_o, lo_o, busy_o); n_fail++;
        end
    endtask

    task automatic test_unknown();
        issue_op(OP_MTHI, 32'h5A5A_5A5A, 32'd0, "unk_prep");
        issue_op(3'd6, 32'hFFFF_FFFF, 32'd0, "unknown_6");
        issue_op(3'd7, 32'h1234_0000, 32'd9, "unknown_7");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        run_div(OP_DIV, $urandom, $urandom | 32'd1, "b2b_div", 1'b1);
        a = $urandom; b = $urandom;
        op_i = OP_MULT; src_a_i = a; src_b_i = b;
        #1;
        n_tests++;
        if (stall_o !== 1'b0) begin
            $display("FAIL b2b stall_o got %b want 0", stall_o); n_fail++;
        end
        @(negedge clk);
        start_i = 1'b0;
        {m_hi, m_lo} = ref_hilo(OP_MULT, a, b, m_hi, m_lo);
        n_tests++;
        if (hi_o !== m_hi || lo_o !== m_lo) begin
            $display("FAIL b2b_mult hilo got %h_%h want %h_%h", hi_o, lo_o, m_hi, m_lo); n_fail++;
        end
        n_tests++;
        if (busy_o !== 1'b0) begin
            $display("FAIL b2b busy_o got %b want 0", busy_o); n_fail++;
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (op == OP_DIV || op == OP_DIVU) run_div(op, a, b, "rand_div", 1'b0);
            else issue_op(op, a, b, "rand_op");
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_mthilo();
        test_div();
        test_flush();
        test_unknown();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
